// File: rtl/branch_chooser.sv
// Tournament chooser: per-index 2-bit counters choose between two predictors, with an in-flight FIFO for resolution.
// Optional mispredict statistic counter is built only when CHOOSER_STATS_EN is defined.
module branch_chooser #(
    parameter int IDX_BITS = 4,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        p1_pred,
    input  logic        p2_pred,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic        flush,
    output logic        pred_taken,
    output logic        pred_sel,
    output logic        stall,
    output logic        mispredict,
    output logic        p1_wrong,
    output logic        p2_wrong,
    output logic [15:0] mispredict_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [IDX_BITS-1:0] fetch_idx;
    logic                unused_pc_bits;
    logic [1:0]          ctr [ENTRIES];

    logic [IDX_BITS-1:0] q_idx [DEPTH];
    logic                q_p1  [DEPTH];
    logic                q_p2  [DEPTH];
    logic                q_sel [DEPTH];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                push;
    logic                pop;
    logic [IDX_BITS-1:0] h_idx;
    logic                h_p1;
    logic                h_p2;
    logic                h_sel;
    logic                h_chosen;
    logic                inc_en;
    logic                dec_en;

    assign fetch_idx      = fetch_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not visible here.
    assign pred_sel   = ctr[fetch_idx][1];
    assign pred_taken = pred_sel ? p2_pred : p1_pred;

    assign stall = (count == CNT_W'(DEPTH));
    assign push  = fetch_valid & ~stall & ~flush;
    assign pop   = resolve_valid & (count != '0);

    assign h_idx    = q_idx[rd_ptr];
    assign h_p1     = q_p1[rd_ptr];
    assign h_p2     = q_p2[rd_ptr];
    assign h_sel    = q_sel[rd_ptr];
    assign h_chosen = h_sel ? h_p2 : h_p1;

    assign inc_en = pop & (h_p2 == resolve_taken) & (h_p1 != resolve_taken);
    assign dec_en = pop & (h_p1 == resolve_taken) & (h_p2 != resolve_taken);

    // FIFO payload: pointers and count alone decide what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr] <= fetch_idx;
            q_p1[wr_ptr]  <= p1_pred;
            q_p2[wr_ptr]  <= p2_pred;
            q_sel[wr_ptr] <= pred_sel;
        end
    end

    // Control: pointers, occupancy, resolution flags and chooser table
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mispredict <= 1'b0;
            p1_wrong   <= 1'b0;
            p2_wrong   <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else begin
            mispredict <= pop & (h_chosen != resolve_taken);
            p1_wrong   <= pop & (h_p1 != resolve_taken);
            p2_wrong   <= pop & (h_p2 != resolve_taken);

            if (inc_en) begin
                ctr[h_idx] <= sat_inc2(ctr[h_idx]);
            end else if (dec_en) begin
                ctr[h_idx] <= sat_dec2(ctr[h_idx]);
            end

            // Flush lets the resolve above complete, then drops everything in flight.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_next(wr_ptr);
                if (pop)  rd_ptr <= ptr_next(rd_ptr);
                unique case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef CHOOSER_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [15:0] stat_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else if (mispredict) begin
            stat_cnt <= sat_inc16(stat_cnt);
        end
    end

    assign mispredict_cnt = stat_cnt;
`else
    assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_chooser.sv
// Scoreboard bench for branch_chooser: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_branch_chooser;

    logic        clk = 1'b1;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        p1_pred;
    logic        p2_pred;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        flush;
    logic        pred_taken;
    logic        pred_sel;
    logic        stall;
    logic        mispredict;
    logic        p1_wrong;
    logic        p2_wrong;
    logic [15:0] mispredict_cnt;

    typedef struct {
        string nm;
        int    sel;
        int    taken;
        int    stl;
        int    flags;
        int    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    branch_chooser #(.IDX_BITS(4), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .p1_pred       (p1_pred),
        .p2_pred       (p2_pred),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .flush         (flush),
        .pred_taken    (pred_taken),
        .pred_sel      (pred_sel),
        .stall         (stall),
        .mispredict    (mispredict),
        .p1_wrong      (p1_wrong),
        .p2_wrong      (p2_wrong),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, string what, int act, int want);
        if (want < 0) return;
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s %s: got %0d, expected %0d", nm, what, act, want);
        end
    endfunction

    // Monitor: one expectation per driven cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "pred_sel", int'(pred_sel), e.sel);
            chk(e.nm, "pred_taken", int'(pred_taken), e.taken);
            chk(e.nm, "stall", int'(stall), e.stl);
            chk(e.nm, "flags", int'({mispredict, p1_wrong, p2_wrong}), e.flags);
            chk(e.nm, "mispredict_cnt", int'(mispredict_cnt), e.cnt);
        end
    end

    task automatic cyc(input bit rn, input bit fv, input logic [31:0] pc, input bit p1,
                       input bit p2, input bit rv, input bit rt, input bit fl,
                       input int e_sel, input int e_taken, input int e_stall,
                       input int e_flags, input int e_cnt);
        exp_t e;
        rst_n         = rn;
        fetch_valid   = fv;
        fetch_pc      = pc;
        p1_pred       = p1;
        p2_pred       = p2;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
        e.nm    = $sformatf("C%0d", cyc_no);
        e.sel   = e_sel;
        e.taken = e_taken;
        e.stl   = e_stall;
        e.flags = e_flags;
`ifdef CHOOSER_STATS_EN
        e.cnt   = e_cnt;
`else
        e.cnt   = (e_cnt < 0) ? -1 : 0;
`endif
        exp_q.push_back(e);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; p1_pred = 1'b0; p2_pred = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
        #1;
        //   rn fv pc     p1 p2 rv rt fl   sel tkn stl flags  cnt
        cyc(0, 0, 32'h00, 0, 0, 0, 0, 0,  -1, -1, -1, -1,    -1);
        cyc(0, 1, 32'h40, 1, 1, 1, 1, 1,  -1, -1, -1, -1,    -1);
        cyc(1, 1, 32'h40, 1, 0, 0, 0, 0,   0,  1,  0, 'b000,  0);
        cyc(1, 0, 32'h00, 0, 0, 1, 1, 0,  -1, -1,  0, 'b000, -1);
        cyc(1, 1, 32'h40, 1, 0, 0, 0, 0,   0,  1,  0, 'b001, -1);
        cyc(0, 1, 32'h40, 0, 1, 1, 1, 1,  -1, -1, -1, -1,    -1);
        cyc(1, 1, 32'h40, 0, 1, 0, 0, 0,   0,  0,  0, 'b000,  0);
        cyc(1, 1, 32'h40, 0, 1, 1, 1, 0,   0,  0,  0, 'b000, -1);
        cyc(1, 1, 32'h40, 0, 1, 1, 1, 0,   1,  1,  0, 'b110, -1);
        cyc(1, 1, 32'h40, 0, 1, 1, 1, 0,   1,  1,  0, 'b110, -1);
        cyc(1, 1, 32'h44, 1, 0, 0, 0, 0,   0,  1,  0, 'b010,  2);
        cyc(1, 1, 32'h48, 0, 1, 0, 0, 0,   0,  0,  0, 'b000, -1);
        cyc(1, 1, 32'h4C, 1, 1, 0, 0, 0,   0,  1,  0, 'b000, -1);
        cyc(1, 1, 32'h50, 0, 0, 1, 1, 0,   0,  0,  1, 'b000, -1);
        cyc(1, 1, 32'h54, 1, 0, 0, 0, 0,   0,  1,  0, 'b010, -1);
        cyc(1, 0, 32'h00, 0, 0, 1, 0, 0,  -1, -1,  1, 'b000, -1);
        cyc(1, 1, 32'h44, 0, 1, 1, 1, 0,   1,  1,  0, 'b110, -1);
        cyc(1, 0, 32'h00, 0, 0, 1, 1, 0,  -1, -1,  0, 'b110, -1);
        cyc(1, 1, 32'h58, 1, 0, 1, 0, 1,   0,  1,  0, 'b000,  4);
        cyc(1, 0, 32'h00, 0, 0, 1, 1, 0,  -1, -1,  0, 'b110, -1);
        cyc(1, 1, 32'h54, 0, 1, 0, 0, 0,   1,  1,  0, 'b000,  5);
        cyc(1, 0, 32'h00, 0, 0, 1, 1, 0,  -1, -1,  0, 'b000, -1);
        cyc(1, 0, 32'h00, 0, 0, 0, 0, 0,  -1, -1,  0, 'b010,  5);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
